// File: rtl/fft_pkg.sv
// Shared types for the FFT stage-0 sequencing controller.
package fft_pkg;

    localparam int LANES = 16;
    // Width of the frame index carried through the flag delay line.
    localparam int FRM_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             sof;
        logic             eof;
        logic [FRM_W-1:0] cnt;
    } flag_t;

endpackage

// File: rtl/fft_stg00_ctrl_if.sv
// Input framing and stage-0 control bundle between controller and its neighbours.
interface fft_stg00_ctrl_if #(
    parameter int CNT_W = fft_pkg::FRM_W
);
    logic             din_valid;
    logic             din_sof;
    logic             bfly_en;
    logic             twd_valid;
    logic [CNT_W-1:0] twd_cnt;
    logic             twd_idx;
    logic             out_valid;
    logic             out_sof;
    logic             out_eof;
    logic             busy;
    logic             frame_done;
    logic             err_sof;

    modport master (
        output din_valid, din_sof,
        input  bfly_en, twd_valid, twd_cnt, twd_idx,
        input  out_valid, out_sof, out_eof,
        input  busy, frame_done, err_sof
    );

    modport slave (
        input  din_valid, din_sof,
        output bfly_en, twd_valid, twd_cnt, twd_idx,
        output out_valid, out_sof, out_eof,
        output busy, frame_done, err_sof
    );
endinterface

// File: rtl/fft_flag_dly.sv
// PIPE_LAT-deep shift of control flags tracking words through stage 0.
module fft_flag_dly
    import fft_pkg::*;
#(
    parameter int PIPE_LAT = 2
) (
    input  logic  clk,
    input  logic  clr_i,
    input  flag_t d_i,
    output flag_t first_o,
    output logic  out_valid_o,
    output logic  out_sof_o,
    output logic  out_eof_o,
    output logic  pend_o
);

    flag_t stg_q [PIPE_LAT];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q[0] <= d_i;
            for (int i = 1; i < PIPE_LAT; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    // Words still in flight after the one leaving the final stage.
    always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < PIPE_LAT - 1; i++) begin
            pend_o = pend_o | stg_q[i].valid;
        end
    end

    assign first_o     = stg_q[0];
    assign out_valid_o = stg_q[PIPE_LAT-1].valid;
    assign out_sof_o   = stg_q[PIPE_LAT-1].sof;
    assign out_eof_o   = stg_q[PIPE_LAT-1].eof;

endmodule

// File: rtl/fft_stg00_ctrl.sv
// Stage-0 frame sequencer: frames input words, drives butterfly enable
// and twiddle select, and aligns sof/eof/valid to the stage output.
module fft_stg00_ctrl
    import fft_pkg::*;
#(
    parameter int CNT_W    = FRM_W,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    fft_stg00_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST = '1;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] idx;
    logic             err_q;
    logic             acc;
    logic             pend;
    flag_t            din_f;
    flag_t            twd_f;

    // cnt_q == 0 in RUN only after a wrap: only a new sof may enter then.
    always_comb begin
        acc = 1'b0;
        idx = cnt_q;
        unique case (state_q)
            IDLE, DRAIN: acc = bus.din_valid & bus.din_sof;
            RUN:         acc = bus.din_valid & (bus.din_sof | (cnt_q != '0));
            default:     acc = 1'b0;
        endcase
        if (bus.din_sof) begin
            idx = '0;
        end
        cnt_d = acc ? idx + CNT_W'(1) : cnt_q;
    end

    always_comb begin
        din_f       = '0;
        din_f.valid = acc;
        din_f.sof   = acc & (idx == '0);
        din_f.eof   = acc & (idx == LAST);
        din_f.cnt   = acc ? idx : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == RUN && acc && bus.din_sof && cnt_q != '0) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (acc) state_q <= RUN;
                end
                RUN: begin
                    if (!acc && cnt_q == '0) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (acc)        state_q <= RUN;
                    else if (!pend) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fft_flag_dly #(
        .PIPE_LAT (PIPE_LAT)
    ) u_dly (
        .clk         (clk),
        .clr_i       (rst),
        .d_i         (din_f),
        .first_o     (twd_f),
        .out_valid_o (bus.out_valid),
        .out_sof_o   (bus.out_sof),
        .out_eof_o   (bus.out_eof),
        .pend_o      (pend)
    );

    assign bus.bfly_en    = acc;
    assign bus.twd_valid  = twd_f.valid;
    assign bus.twd_cnt    = twd_f.cnt;
    assign bus.twd_idx    = twd_f.cnt[CNT_W-1];
    assign bus.frame_done = bus.out_eof;
    assign bus.busy       = (state_q != IDLE);
    assign bus.err_sof    = err_q;

endmodule
